// File: rtl/riscv_enc_pkg.sv
// Shared encoding constants, command codes and loader state enum for the
// instruction stream loader and its field packer.
package riscv_enc_pkg;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100111;

    // BEQ x0,x0,0 with the core's branch opcode: a self-loop terminator.
    localparam logic [31:0] PAD_WORD = 32'h0000_0067;

    typedef enum logic [1:0] {
        CMD_R   = 2'b00,
        CMD_LD  = 2'b01,
        CMD_SD  = 2'b10,
        CMD_BEQ = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PAD   = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Pure combinational packer: symbolic command fields -> 32-bit RV instruction
// word for the R, LD, SD and BEQ classes the core decodes.
module instr_field_packer (
    input  logic [1:0]  op,
    input  logic [2:0]  funct3,
    input  logic        f7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] instr
);
    import riscv_enc_pkg::*;

    always_comb begin
        instr = 32'h0;
        case (op)
            CMD_R:   instr = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OPC_R};
            CMD_LD:  instr = {imm[11:0], rs1, funct3, rd, OPC_LD};
            CMD_SD:  instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_SD};
            // imm holds offset[12:1], so its bit positions are shifted by one.
            CMD_BEQ: instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OPC_BEQ};
            default: instr = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_stream_loader.sv
// Streams symbolic commands into imem as packed instruction words, one per cycle.
// Define INSTR_PAD_EN to append a self-loop terminator word after the last command.
module instr_stream_loader #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [2:0]    cmd_funct3,
    input  logic          cmd_f7b5,
    input  logic [4:0]    cmd_rd,
    input  logic [4:0]    cmd_rs1,
    input  logic [4:0]    cmd_rs2,
    input  logic [11:0]   cmd_imm,
    input  logic          cmd_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   count
);
    import riscv_enc_pkg::*;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          imem_we_q, imem_we_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]   imem_wdata_q, imem_wdata_d;
    logic          overflow_q, overflow_d;

    logic [31:0]   enc_word;
    logic          room;
    logic          accept;
    logic          start_ok;

    instr_field_packer u_packer (
        .op     (cmd_op),
        .funct3 (cmd_funct3),
        .f7b5   (cmd_f7b5),
        .rd     (cmd_rd),
        .rs1    (cmd_rs1),
        .rs2    (cmd_rs2),
        .imm    (cmd_imm),
        .instr  (enc_word)
    );

    // The word counter doubles as the write pointer: both clear and advance together.
    assign room     = (count_q < DEPTH_C);
    assign accept   = cmd_valid && cmd_ready;
    assign start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (accept && cmd_last) begin
`ifdef INSTR_PAD_EN
                    state_d = PAD;
`else
                    state_d = DONE;
`endif
                end else if (!room) begin
                    state_d = ERROR;
                end
            end
`ifdef INSTR_PAD_EN
            PAD: begin
                state_d = room ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == LOAD) && room;
        busy      = (state_q == LOAD) || (state_q == PAD);
        done      = (state_q == DONE);
    end

    always_comb begin
        count_d      = count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        overflow_d   = overflow_q;
        if (start_ok) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = count_q[AW-1:0];
            imem_wdata_d = enc_word;
            count_d      = count_q + (AW+1)'(1);
        end else if (state_q == LOAD && !room) begin
            overflow_d = 1'b1;
        end
`ifdef INSTR_PAD_EN
        else if (state_q == PAD) begin
            if (room) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = count_q[AW-1:0];
                imem_wdata_d = PAD_WORD;
                count_d      = count_q + (AW+1)'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            overflow_q   <= overflow_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign overflow   = overflow_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Self-checking bench for instr_stream_loader: table-driven commands with a
// write scoreboard, plus overflow, restart and mid-load reset sequences.
module tb_instr_stream_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef INSTR_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [2:0]    cmd_funct3;
    logic          cmd_f7b5;
    logic [4:0]    cmd_rd;
    logic [4:0]    cmd_rs1;
    logic [4:0]    cmd_rs2;
    logic [11:0]   cmd_imm;
    logic          cmd_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   count;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        last;
        logic [31:0] word;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[4];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_ptr = 0;
    int   n_acc;

    instr_stream_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_funct3 (cmd_funct3),
        .cmd_f7b5   (cmd_f7b5),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .cmd_last   (cmd_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push(input logic [31:0] word);
        wr_t w;
        w.addr = AW'(exp_ptr);
        w.data = word;
        exp_q.push_back(w);
        exp_ptr++;
    endfunction

    always @(negedge clk) begin : monitor
        wr_t w;
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", imem_addr, imem_wdata);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(w.addr));
                check("wr_data", imem_wdata, w.data);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        cmd_op     = v.op;
        cmd_funct3 = v.f3;
        cmd_f7b5   = v.f7b5;
        cmd_rd     = v.rd;
        cmd_rs1    = v.rs1;
        cmd_rs2    = v.rs2;
        cmd_imm    = v.imm;
        cmd_last   = v.last;
        cmd_valid  = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got cmd_ready=0 expected 1 within 20 cycles");
        end else begin
            push(v.word);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        // The terminator follows the last command whenever there is still room for it.
        if (PAD_ON && v.last && exp_ptr < DEPTH) push(32'h0000_0067);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || overflow) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(done || overflow)) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: got done=0 overflow=0 expected one set within 8 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0] = '{2'b00, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0,    1'b0, 32'h002081B3};
        tbl[1] = '{2'b01, 3'b011, 1'b0, 5'd5, 5'd2, 5'd0, 12'd8,    1'b0, 32'h00813283};
        tbl[2] = '{2'b10, 3'b011, 1'b0, 5'd0, 5'd2, 5'd5, 12'd16,   1'b0, 32'h00513823};
        tbl[3] = '{2'b11, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 12'hFFC,  1'b1, 32'hFE208CE7};

        rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_funct3 = 3'b0;
        cmd_f7b5 = 1'b0; cmd_rd = 5'd0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_imm = 12'd0; cmd_last = 1'b0;
        #1;
        check("rst_we",       32'(imem_we),    32'd0);
        check("rst_addr",     32'(imem_addr),  32'd0);
        check("rst_wdata",    imem_wdata,      32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_done",     32'(done),       32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_count",    32'(count),      32'd0);
        check("rst_ready",    32'(cmd_ready),  32'd0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-depth program: last command lands on the final free word.
        do_start();
        check("load_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send(tbl[i]);
        wait_end();
        check("full_done",     32'(done),      PAD_ON ? 32'd0 : 32'd1);
        check("full_overflow", 32'(overflow),  PAD_ON ? 32'd1 : 32'd0);
        check("full_count",    32'(count),     32'd4);
        check("full_busy",     32'(busy),      32'd0);
        check("full_ready",    32'(cmd_ready), 32'd0);

        // Restart from DONE/ERROR with a single-branch program.
        do_start();
        check("restart_done",     32'(done),     32'd0);
        check("restart_overflow", 32'(overflow), 32'd0);
        check("restart_count",    32'(count),    32'd0);
        send(tbl[3]);
        wait_end();
        check("beq_done",     32'(done),     32'd1);
        check("beq_count",    32'(count),    PAD_ON ? 32'd2 : 32'd1);
        check("beq_overflow", 32'(overflow), 32'd0);

        // Five commands without last into four words.
        do_start();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_funct3 = 3'b0; cmd_f7b5 = 1'b0;
        cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_imm = 12'd0; cmd_last = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_rd = 5'(n_acc + 1);
            if (cmd_ready && n_acc < 5) begin
                push(32'h0000_0033 | (32'(n_acc + 1) << 7));
                n_acc++;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("ovf_accepts",  32'(n_acc),     32'd4);
        check("ovf_overflow", 32'(overflow),  32'd1);
        check("ovf_done",     32'(done),      32'd0);
        check("ovf_ready",    32'(cmd_ready), 32'd0);
        check("ovf_count",    32'(count),     32'd4);
        do_start();
        check("ovf_clr_overflow", 32'(overflow), 32'd0);
        check("ovf_clr_count",    32'(count),    32'd0);
        check("ovf_clr_busy",     32'(busy),     32'd1);

        // Two writes, an ignored start, then reset aborts the load.
        send(tbl[0]);
        send(tbl[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_start_count", 32'(count), 32'd2);
        check("ign_start_busy",  32'(busy),  32'd1);
        #3;
        cmd_op = tbl[2].op; cmd_rs1 = tbl[2].rs1; cmd_rs2 = tbl[2].rs2; cmd_imm = tbl[2].imm;
        cmd_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_we",    32'(imem_we), 32'd0);
        check("arst_busy",  32'(busy),    32'd0);
        check("arst_count", 32'(count),   32'd0);
        #2;
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy",  32'(busy),      32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd0);
        check("post_rst_done",  32'(done),      32'd0);
        check("queue_empty",    32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
